// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam logic UART_STOP_LEVEL = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 217;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_shifter.sv
// 9-bit right shift register for the transmit data; refills with the stop level
// so the idle/stop value is always what falls out of the low end.
module uart_tx_shifter
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] in,
  output logic       bit0,
  output logic       bit1
);

  logic [UART_DATA_BITS:0] q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '1;
    end else if (load) begin
      q <= {UART_STOP_LEVEL, in};
    end else if (shift) begin
      q <= {UART_STOP_LEVEL, q[UART_DATA_BITS:1]};
    end
  end

  assign bit0 = q[0];
  assign bit1 = q[1];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 framing with a registered, glitch-free tx line.
// Define UART_TX_PARITY_EN to add an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       load,
  output logic       tx,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_START = START;
  localparam logic [2:0] S_DATA  = DATA;
  localparam logic [2:0] S_STOP  = STOP;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = PARITY;
`endif

  logic [2:0]       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic             bit_end;
  logic             accept;
  logic             shift_en;
  logic             sh_bit0;
  logic             sh_bit1;

  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign accept   = (state == S_IDLE) && load;
  assign shift_en = (state == S_DATA) && bit_end;

  uart_tx_shifter u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (shift_en),
    .in    (in),
    .bit0  (sh_bit0),
    .bit1  (sh_bit1)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^in;
    end
  end
`endif

  // tx is registered, so each bit boundary loads the level of the bit about to start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      tx       <= UART_STOP_LEVEL;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (state == S_IDLE || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (load) begin
            state <= S_START;
            tx    <= UART_START_LEVEL;
            busy  <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            bit_cnt <= '0;
            tx      <= sh_bit0;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              tx    <= parity_q;
`else
              state <= S_STOP;
              tx    <= UART_STOP_LEVEL;
`endif
            end else begin
              tx <= sh_bit1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state <= S_STOP;
            tx    <= UART_STOP_LEVEL;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= UART_STOP_LEVEL;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle line model built from frame bit lists, plus a
// mid-bit serial decoder feeding a byte scoreboard.
module tb_uart_tx;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] in;
  logic       load;
  logic       tx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .load  (load),
    .tx    (tx),
    .busy  (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: the expected line level for every cycle of the frame
  logic       mq[$];
  logic [7:0] exp_q[$];
  int accepted = 0;
  int aborted = 0;
  bit checking = 0;

  always @(posedge clk) begin
    bit was_empty;
    logic [FRAME_BITS-1:0] levels;
    was_empty = (mq.size() == 0);
    if (reset) begin
      if (!was_empty) aborted++;
      mq.delete();
      exp_q.delete();
    end else if (!was_empty) begin
      void'(mq.pop_front());
    end else if (load) begin
`ifdef UART_TX_PARITY_EN
      levels = {1'b1, ^in, in, 1'b0};
`else
      levels = {1'b1, in, 1'b0};
`endif
      for (int b = 0; b < FRAME_BITS; b++)
        for (int k = 0; k < C; k++) mq.push_back(levels[b]);
      exp_q.push_back(in);
      accepted++;
    end
  end

  // per-cycle compare, busy-length tracking and serial decode
  int busy_run = 0;
  int last_busy_len = 0;
  bit mon_active = 0;
  int mon_t = 0;
  logic [7:0] mon_byte;
  int decoded = 0;

  always @(negedge clk) begin
    if (checking) begin
      chk("tx_line", tx, (mq.size() != 0) ? mq[0] : 1'b1);
      chk("busy", busy, mq.size() != 0);
    end
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_busy_len = busy_run;
      busy_run = 0;
    end
    if (reset) begin
      mon_active = 0;
    end else begin
      if (!mon_active && checking && tx == 1'b0) begin
        mon_active = 1;
        mon_t = 0;
      end
      if (mon_active) begin
        if (mon_t % C == C / 2) begin
          int k;
          k = mon_t / C;
          if (k == 0) chk("start_bit", tx, 0);
          else if (k <= 8) mon_byte[k-1] = tx;
`ifdef UART_TX_PARITY_EN
          else if (k == 9) chk("parity_bit", tx, ^mon_byte);
`endif
          if (k == FRAME_BITS - 1) begin
            chk("stop_bit", tx, 1);
            if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
            else chk("rx_byte", mon_byte, exp_q.pop_front());
            decoded++;
            mon_active = 0;
          end
        end
        mon_t++;
      end
    end
  end

  // driver tasks; all start and end at posedge + 1
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    load = 1'b1;
    in = b;
    step(1);
    load = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step(1);
      n++;
    end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    load = 1'b1;
    in = 8'hA5;
    step(1);
    checking = 1;
    step(1);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    reset = 1'b0;
    load = 1'b0;
    step(8);
    chk("no_start_after_reset", busy, 0);

    send_byte(8'h55);
    wait_idle(200);
    step(2);
    chk("busy_len_55", last_busy_len, FRAME_BITS * C);
    chk("tx_after_55", tx, 1);

    send_byte(8'hF0);
    step(15);
    send_byte(8'h0F);
    wait_idle(200);
    step(2 * C);
    chk("no_second_frame", busy, 0);

    load = 1'b1;
    in = 8'h00;
    step(1);
    in = 8'hFF;
    wait_idle(200);
    step(1);
    chk("b2b_gap", busy, 1);
    load = 1'b0;
    wait_idle(200);
    step(3);

    send_byte(8'h3C);
    step(4 * C + 1);
    reset = 1'b1;
    step(1);
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    reset = 1'b0;
    step(3);
    send_byte(8'h81);
    wait_idle(200);
    step(2);

`ifdef UART_TX_PARITY_EN
    send_byte(8'h07);
    wait_idle(200);
    step(2);
    chk("busy_len_par", last_busy_len, FRAME_BITS * C);
    send_byte(8'h03);
    wait_idle(200);
    step(2);
`endif

    for (int i = 0; i < 20; i++) begin
      int mode;
      mode = $urandom_range(0, 2);
      if (mode == 1) begin
        load = 1'b1;
        in = 8'($urandom_range(0, 255));
        step($urandom_range(1, 3));
        load = 1'b0;
      end else begin
        send_byte(8'($urandom_range(0, 255)));
        if (mode == 2) begin
          step($urandom_range(1, 20));
          send_byte(8'($urandom_range(0, 255)));
        end
      end
      wait_idle(200);
      step($urandom_range(0, 3));
    end
    step(2 * C);

    chk("frame_count", decoded, accepted - aborted);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter, 8N1 framing: start bit (0), 8 data bits LSB first, stop bit (1).
- Counterpart of the existing right-shifting receive shift register: loads a parallel byte and shifts it out LSB first on a single line.
- Sits between the CPU's memory-mapped UART register and the board TX pin.
- Line idles high.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per serial bit (25 MHz / 115200 baud); legal range 2..65535.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  8  byte to transmit; sampled only on an accepted load.
- load  input  1  request to send `in`; single-cycle pulse or held high.
- tx  output  1  serial line to pin; registered output.
- busy  output  1  1 from the cycle after an accepted load until the stop bit (or parity/stop sequence) completes; registered.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous, active-high.
- Reset values: tx=1, busy=0, state=IDLE, bit counter=0, baud counter=0, shift register=all ones.
- Reset mid-frame: abort the frame; tx=1 and busy=0 from the next edge; no partial stop bit is emitted.
- Accept rule: load=1 while busy=0 (state IDLE) at a rising edge is accepted.
  - At that edge: shift register <= {1'b1, in}; tx <= 0 (start bit); busy <= 1; baud counter <= 0.
  - load while busy=1 is ignored; `in` is not sampled.
- States:
  - IDLE: tx=1. On an accepted load, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit counter=0.
  - DATA: tx = shift[0] for CLKS_PER_BIT cycles per bit. At the end of each bit, shift right, inserting 1 at the MSB, and increment the bit counter. After bit 7, go to STOP (or PARITY if enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the final cycle, busy <= 0 and state <= IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1; wraps to 0 at the bit boundary. Width is $clog2(CLKS_PER_BIT).
- Frame length: exactly 10*CLKS_PER_BIT cycles from the first cycle tx=0 to the first cycle busy=0.
- Back-to-back frames: load held high is accepted in the first cycle busy=0. The next start bit begins on the following edge, giving one idle-high cycle between frames (inter-frame gap of 1 clk).
- Glitch-free output: tx changes only at bit boundaries.
- Simultaneous reset and load: reset wins; the load is dropped.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits), held for CLKS_PER_BIT cycles.
  - Parity is computed at load time and stored in a 1-bit register.
  - Frame length becomes 11*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity register; 8N1 framing only.

Decomposition:
- Package uart_pkg holds:
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - UART_DATA_BITS=8.
  - UART_STOP_LEVEL=1.
  - UART_START_LEVEL=0.
  - Default CLKS_PER_BIT.
- Sub-module uart_tx_shifter:
  - 9-bit right shift register with load/shift controls, inserting 1 at the MSB; out[0] feeds tx during DATA.
  - The FSM and baud counter stay in uart_tx.

Test Plan:
- Reset: assert reset 2 cycles with load=1, in=0xA5 -> tx=1 and busy=0 throughout; no start bit follows release.
- Single byte: CLKS_PER_BIT=4, load pulse with in=0x55.
  - busy=1 for 40 cycles.
  - tx sequence per 4-cycle bit: 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop).
  - tx=1 afterward.
- Ignored load: load in=0x0F mid-frame of 0xF0 -> the transmitted data bits remain 0,0,0,0,1,1,1,1; no second frame starts.
- Back-to-back: load held high with in=0x00, then 0xFF -> two frames with exactly 1 idle-high cycle between stop bit and next start bit.
- Reset mid-frame: reset during data bit 3 of 0x3C -> tx=1 and busy=0 next cycle; a later load of 0x81 is sent correctly.
- UART_TX_PARITY_EN: in=0x07 -> parity bit 1 between data and stop; busy lasts 44 cycles at CLKS_PER_BIT=4. in=0x03 -> parity bit 0.
